// File: rtl/mt9v032_deframer_pkg.sv
// rtl/mt9v032_deframer_pkg.sv - shared state encodings, framing bit positions and width helpers
package mt9v032_deframer_pkg;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int START_POS = 0;

  function automatic int stop_pos(input int frame);
    return frame - 1;
  endfunction

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mt9v032_deframer_lane.sv
// rtl/mt9v032_deframer_lane.sv - one lane: two-frame window, alignment search/verify/lock FSM
// and the registered payload at the current bit offset.
module mt9v032_deframer_lane
  import mt9v032_deframer_pkg::*;
#(
  parameter int  DATA     = 10,
  parameter int  LOCK_CNT = 16,
  parameter int  ERR_CNT  = 4,
  localparam int FRAME    = DATA + 2,
  localparam int OW       = clog2(FRAME)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [FRAME-1:0] in_frame,
  input  logic             retrain,
  input  logic             inhibit,
  output logic [DATA-1:0]  payload,
  output logic             err,
  output logic             lock,
  output logic [OW-1:0]    offset
);

  localparam int            CW       = clog2(LOCK_CNT + 1);
  localparam int            EW       = clog2(ERR_CNT + 1);
  localparam int            STOP_POS = stop_pos(FRAME);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_CNT);
  localparam logic [EW-1:0] ERR_ONE  = EW'(1);
  localparam logic [EW-1:0] ERR_LAST = EW'(ERR_CNT);
  localparam logic [OW-1:0] OFF_ONE  = OW'(1);
  localparam logic [OW-1:0] OFF_LAST = OW'(FRAME - 1);

  logic [1:0]         state;
  logic [FRAME-1:0]   prev;
  logic [CW-1:0]      cnt;
  logic [EW-1:0]      errcnt;
  logic [2*FRAME-1:0] win;
  logic [FRAME-1:0]   cand;
  logic               good;
  logic [OW-1:0]      offset_adv;
  logic [CW-1:0]      cnt_inc;
  logic [EW-1:0]      errcnt_inc;

  // prev holds the earlier bits, so offset 0 selects the previous frame verbatim.
  assign win        = {in_frame, prev};
  assign cand       = FRAME'(win >> offset);
  assign good       = cand[START_POS] & ~cand[STOP_POS];
  assign cnt_inc    = cnt + CNT_ONE;
  assign errcnt_inc = errcnt + ERR_ONE;
  assign lock       = (state == ST_LOCKED);

  always_comb begin
    offset_adv = offset;
    if (!inhibit) begin
      offset_adv = (offset == OFF_LAST) ? '0 : offset + OFF_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_SEARCH;
      prev    <= '0;
      cnt     <= '0;
      errcnt  <= '0;
      offset  <= '0;
      payload <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      if (in_valid) begin
        prev    <= in_frame;
        payload <= cand[FRAME-2:1];
      end
      if (retrain) begin
        state  <= ST_SEARCH;
        cnt    <= '0;
        errcnt <= '0;
        offset <= '0;
      end else if (in_valid) begin
        case (state)
          ST_SEARCH: begin
            if (good) begin
              if (LOCK_CNT == 1) begin
                state <= ST_LOCKED;
                cnt   <= '0;
              end else begin
                state <= ST_VERIFY;
                cnt   <= CNT_ONE;
              end
            end else begin
              offset <= offset_adv;
            end
          end
          ST_VERIFY: begin
            if (good) begin
              if (cnt_inc == CNT_LAST) begin
                state <= ST_LOCKED;
                cnt   <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state  <= ST_SEARCH;
              cnt    <= '0;
              offset <= offset_adv;
            end
          end
          ST_LOCKED: begin
            if (good) begin
              errcnt <= '0;
            end else begin
              err <= 1'b1;
              // Offset is kept on loss so the last good alignment is retried first.
              if (errcnt_inc == ERR_LAST) begin
                state  <= ST_SEARCH;
                errcnt <= '0;
              end else begin
                errcnt <= errcnt_inc;
              end
            end
          end
          default: begin
            state  <= ST_SEARCH;
            cnt    <= '0;
            errcnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/mt9v032_deframer.sv
// rtl/mt9v032_deframer.sv - multi-lane word aligner: per-lane framing lock, output gated on
// all lanes being locked.
module mt9v032_deframer
  import mt9v032_deframer_pkg::*;
#(
  parameter int  CHANNELS = 1,
  parameter int  DATA     = 10,
  parameter int  LOCK_CNT = 16,
  parameter int  ERR_CNT  = 4,
  localparam int FRAME    = DATA + 2,
  localparam int OW       = clog2(FRAME)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [CHANNELS*FRAME-1:0] in_data,
  input  logic                      retrain,
  input  logic                      inhibit,
  output logic                      out_valid,
  output logic [CHANNELS*DATA-1:0]  out_data,
  output logic [CHANNELS-1:0]       out_err,
  output logic [CHANNELS-1:0]       lock,
  output logic                      all_locked,
  output logic [CHANNELS*OW-1:0]    offset
);

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_lane
      mt9v032_deframer_lane #(
        .DATA     (DATA),
        .LOCK_CNT (LOCK_CNT),
        .ERR_CNT  (ERR_CNT)
      ) u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_frame (in_data[c*FRAME +: FRAME]),
        .retrain  (retrain),
        .inhibit  (inhibit),
        .payload  (out_data[c*DATA +: DATA]),
        .err      (out_err[c]),
        .lock     (lock[c]),
        .offset   (offset[c*OW +: OW])
      );
    end
  endgenerate

  assign all_locked = &lock;

  // all_locked here is still the pre-update lock state of this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid & all_locked;
    end
  end

endmodule
